// File: rtl/btn_updown_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_updown_counter_if : button inputs and LED/flag outputs, rev 1.0
// ---------------------------------------------------------------------------
interface btn_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             btn_west;
  logic             btn_east;
  logic             btn_clr;
  logic [WIDTH-1:0] led;
  logic             at_max;
  logic             at_min;

  modport master (
    output btn_west, btn_east, btn_clr,
    input  led, at_max, at_min
  );

  modport slave (
    input  btn_west, btn_east, btn_clr,
    output led, at_max, at_min
  );
endinterface
`default_nettype wire

// File: rtl/btn_updown_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_updown_counter : debounced up/down/clear counter with auto-repeat, rev 1.0
// ---------------------------------------------------------------------------
module btn_updown_counter #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE     = 123456,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1,
  parameter bit SIGNED       = 1'b1,
  parameter bit WRAP         = 1'b0
) (
  input  wire                   clk,
  input  wire                   reset,
  btn_updown_counter_if.slave   bus
);

  localparam int               c_DBW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] c_MAX     = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_MIN     = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  // Channel 0 = increment (west), 1 = decrement (east), 2 = clear
  wire [2:0] w_raw = {bus.btn_clr, bus.btn_east, bus.btn_west};
  wire [2:0] w_step;

  logic [WIDTH-1:0] r_value;
  wire              w_at_max = (r_value == c_MAX);
  wire              w_at_min = (r_value == c_MIN);

  for (genvar i = 0; i < 3; i++) begin : g_chan
    logic             r_sync1;
    logic             r_sync2;
    logic             r_lvl;
    logic             r_lvl_d;
    logic [c_DBW-1:0] r_db_cnt;
    wire              w_press = r_lvl & ~r_lvl_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_lvl    <= 1'b0;
        r_lvl_d  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_sync1 <= w_raw[i];
        r_sync2 <= r_sync1;
        r_lvl_d <= r_lvl;
        if (r_sync2 == r_lvl) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          r_lvl    <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    if (i < 2 && REPEAT_DELAY > 0) begin : g_repeat
      localparam int c_HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int c_HW       = $clog2(c_HOLD_MAX + 1);

      // r_hold counts cycles since the last step; it never passes the current target
      logic [c_HW-1:0] r_hold;
      logic            r_rep_phase;
      wire  [c_HW-1:0] w_target = r_rep_phase ? c_HW'(REPEAT_RATE) : c_HW'(REPEAT_DELAY);
      wire             w_rep    = r_lvl & r_lvl_d & (r_hold == w_target);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_hold      <= '0;
          r_rep_phase <= 1'b0;
        end else if (!r_lvl) begin
          r_hold      <= '0;
          r_rep_phase <= 1'b0;
        end else if (w_press || w_rep) begin
          r_hold      <= c_HW'(1);
          r_rep_phase <= r_rep_phase | w_rep;
        end else if (r_hold != w_target) begin
          r_hold      <= r_hold + 1'b1;
        end
      end

      assign w_step[i] = w_press | w_rep;
    end else begin : g_no_repeat
      assign w_step[i] = w_press;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (w_step[2]) begin
      r_value <= '0;
    end else if (w_step[0] && !w_step[1]) begin
      if (WRAP || !w_at_max) begin
        r_value <= r_value + 1'b1;
      end
    end else if (w_step[1] && !w_step[0]) begin
      if (WRAP || !w_at_min) begin
        r_value <= r_value - 1'b1;
      end
    end
  end

  assign bus.led    = r_value;
  assign bus.at_max = w_at_max;
  assign bus.at_min = w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_btn_updown_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_updown_counter : self-checking bench, four parameter sets, rev 1.0
// ---------------------------------------------------------------------------
module tb_btn_updown_counter;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic west  = 1'b0;
  logic east  = 1'b0;
  logic clr   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  btn_updown_counter_if #(.WIDTH(4)) if_a ();
  btn_updown_counter_if #(.WIDTH(4)) if_b ();
  btn_updown_counter_if #(.WIDTH(4)) if_c ();
  btn_updown_counter_if #(.WIDTH(8)) if_d ();

  assign if_a.btn_west = west; assign if_a.btn_east = east; assign if_a.btn_clr = clr;
  assign if_b.btn_west = west; assign if_b.btn_east = east; assign if_b.btn_clr = clr;
  assign if_c.btn_west = west; assign if_c.btn_east = east; assign if_c.btn_clr = clr;
  assign if_d.btn_west = west; assign if_d.btn_east = east; assign if_d.btn_clr = clr;

  // A: signed saturate, B: signed wrap, C: unsigned wrap, D: unsigned saturate + auto-repeat
  btn_updown_counter #(.WIDTH(4), .DEBOUNCE(DB), .REPEAT_DELAY(0), .REPEAT_RATE(1),
                       .SIGNED(1'b1), .WRAP(1'b0)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
  btn_updown_counter #(.WIDTH(4), .DEBOUNCE(DB), .REPEAT_DELAY(0), .REPEAT_RATE(1),
                       .SIGNED(1'b1), .WRAP(1'b1)) dut_b (.clk(clk), .reset(rst_n), .bus(if_b));
  btn_updown_counter #(.WIDTH(4), .DEBOUNCE(DB), .REPEAT_DELAY(0), .REPEAT_RATE(1),
                       .SIGNED(1'b0), .WRAP(1'b1)) dut_c (.clk(clk), .reset(rst_n), .bus(if_c));
  btn_updown_counter #(.WIDTH(8), .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                       .SIGNED(1'b0), .WRAP(1'b0)) dut_d (.clk(clk), .reset(rst_n), .bus(if_d));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw sample history, level flips when the last DB synchronised
  // samples all disagree with it; steps are timed from the edge the level rose.
  logic [DB+1:0] m_hist [3];
  bit            m_lvl  [3];
  int            m_rise [3];
  int            m_t;
  int            m_va, m_vb, m_vc, m_vd;

  function automatic int upd(input int v, input bit inc, input bit dec, input bit cl,
                             input int lo, input int hi, input bit wrap);
    if (cl) return 0;
    if (inc && !dec) return (v < hi) ? v + 1 : (wrap ? lo : v);
    if (dec && !inc) return (v > lo) ? v - 1 : (wrap ? hi : v);
    return v;
  endfunction

  function automatic logic [31:0] pack(input int v, input int lo, input int hi, input int w);
    logic [31:0] r;
    r = 32'(v) & ((32'd1 << w) - 32'd1);
    if (v == lo) r[w] = 1'b1;
    if (v == hi) r[w+1] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    bit raw [3];
    bit st  [3];
    bit sr  [3];
    if (!rst_n) begin
      m_t = 0; m_va = 0; m_vb = 0; m_vc = 0; m_vd = 0;
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0; m_lvl[b] = 1'b0; m_rise[b] = -1000;
      end
      return;
    end
    m_t++;
    raw[0] = west; raw[1] = east; raw[2] = clr;
    for (int b = 0; b < 3; b++) begin
      int age;
      age   = m_t - 1 - m_rise[b];
      st[b] = m_lvl[b] && (age == 0);
      sr[b] = m_lvl[b] && (age == 0 || (age >= RD && ((age - RD) % RR) == 0));
      m_hist[b] = {m_hist[b][DB:0], raw[b]};
      if (!m_lvl[b] && (&m_hist[b][DB+1:2])) begin
        m_lvl[b]  = 1'b1;
        m_rise[b] = m_t;
      end else if (m_lvl[b] && !(|m_hist[b][DB+1:2])) begin
        m_lvl[b] = 1'b0;
      end
    end
    m_va = upd(m_va, st[0], st[1], st[2], -8, 7, 1'b0);
    m_vb = upd(m_vb, st[0], st[1], st[2], -8, 7, 1'b1);
    m_vc = upd(m_vc, st[0], st[1], st[2], 0, 15, 1'b1);
    m_vd = upd(m_vd, sr[0], sr[1], st[2], 0, 255, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("mon_a", 32'({if_a.at_max, if_a.at_min, if_a.led}), pack(m_va, -8, 7, 4));
      check("mon_b", 32'({if_b.at_max, if_b.at_min, if_b.led}), pack(m_vb, -8, 7, 4));
      check("mon_c", 32'({if_c.at_max, if_c.at_min, if_c.led}), pack(m_vc, 0, 15, 4));
      check("mon_d", 32'({if_d.at_max, if_d.at_min, if_d.led}), pack(m_vd, 0, 255, 8));
    end
  end

  task automatic press(input bit w, input bit e, input bit c, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      west = w; east = e; clr = c;
      repeat (10) @(negedge clk);
      west = 1'b0; east = 1'b0; clr = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  typedef struct {
    bit         w, e, c;
    int         n;
    logic [3:0] a, b, cv;
    bit         amax, amin;
  } vec_t;

  vec_t tv [12];
  bit   pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    tv[0]  = '{0, 0, 1,  1, 4'h0, 4'h0, 4'h0, 0, 0};
    tv[1]  = '{1, 0, 0,  1, 4'h1, 4'h1, 4'h1, 0, 0};
    tv[2]  = '{0, 1, 0,  1, 4'h0, 4'h0, 4'h0, 0, 0};
    tv[3]  = '{0, 1, 0,  1, 4'hF, 4'hF, 4'hF, 0, 0};
    tv[4]  = '{1, 1, 0,  1, 4'hF, 4'hF, 4'hF, 0, 0};
    tv[5]  = '{0, 0, 1,  1, 4'h0, 4'h0, 4'h0, 0, 0};
    tv[6]  = '{1, 0, 1,  1, 4'h0, 4'h0, 4'h0, 0, 0};
    tv[7]  = '{1, 0, 0,  9, 4'h7, 4'h9, 4'h9, 1, 0};
    tv[8]  = '{1, 0, 0,  1, 4'h7, 4'hA, 4'hA, 1, 0};
    tv[9]  = '{0, 1, 0, 16, 4'h8, 4'hA, 4'hA, 0, 1};
    tv[10] = '{0, 0, 1,  1, 4'h0, 4'h0, 4'h0, 0, 0};
    tv[11] = '{0, 1, 0,  1, 4'hF, 4'hF, 4'hF, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a", 32'({if_a.at_max, if_a.at_min, if_a.led}), 32'h000);
    check("rst_b", 32'({if_b.at_max, if_b.at_min, if_b.led}), 32'h000);
    check("rst_c", 32'({if_c.at_max, if_c.at_min, if_c.led}), 32'h010);
    check("rst_d", 32'({if_d.at_max, if_d.at_min, if_d.led}), 32'h100);
    rst_n = 1'b1;

    // Clean press: led steps on the 7th edge sampling the button high
    repeat (10) @(negedge clk);
    west = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("lat_edge6", 32'(if_a.led), 32'd0);
    @(posedge clk);
    #1 check("lat_edge7", 32'(if_a.led), 32'd1);
    repeat (3) @(negedge clk);
    west = 1'b0;
    repeat (12) @(negedge clk);
    check("lat_single", 32'(if_a.led), 32'd1);

    // Bounce then steady high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      west = pat[i];
    end
    @(negedge clk);
    west = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("bnc_edge6", 32'(if_a.led), 32'd1);
    @(posedge clk);
    #1 check("bnc_edge7", 32'(if_a.led), 32'd2);
    repeat (4) @(negedge clk);
    west = 1'b0;
    repeat (12) @(negedge clk);
    check("bnc_single", 32'(if_a.led), 32'd2);

    // Table of button presses across the range boundaries
    for (int i = 0; i < 12; i++) begin
      press(tv[i].w, tv[i].e, tv[i].c, tv[i].n);
      check($sformatf("vec%0d_a", i), 32'({if_a.at_max, if_a.at_min, if_a.led}),
            32'({tv[i].amax, tv[i].amin, tv[i].a}));
      check($sformatf("vec%0d_b", i), 32'(if_b.led), 32'(tv[i].b));
      check($sformatf("vec%0d_c", i), 32'(if_c.led), 32'(tv[i].cv));
    end
    check("wrap_c_max", 32'(if_c.at_max), 32'd1);

    // Auto-repeat on D: steps at +0, +20, +28, +36, +44, +52 after the press step
    press(1'b0, 1'b0, 1'b1, 1);
    @(negedge clk);
    west = 1'b1;
    repeat (26) @(posedge clk);
    #1 check("rep_before", 32'(if_d.led), 32'd1);
    @(posedge clk);
    #1 check("rep_first", 32'(if_d.led), 32'd2);
    repeat (33) @(negedge clk);
    west = 1'b0;
    repeat (20) @(negedge clk);
    check("rep_d", 32'(if_d.led), 32'd6);
    check("rep_a", 32'(if_a.led), 32'd1);
    repeat (40) @(negedge clk);
    check("rep_d_after", 32'(if_d.led), 32'd6);

    // Reset mid-hold clears at once; a button still held counts as a new press
    press(1'b0, 1'b0, 1'b1, 1);
    @(negedge clk);
    west = 1'b1;
    repeat (40) @(negedge clk);
    check("hold_d", 32'(if_d.led), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_a", 32'(if_a.led), 32'd0);
    check("async_d", 32'(if_d.led), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("rel_edge6", 32'(if_a.led), 32'd0);
    @(posedge clk);
    #1 check("rel_edge7", 32'(if_a.led), 32'd1);
    @(negedge clk);
    west = 1'b0;
    repeat (15) @(negedge clk);

    // Randomised buttons: short bouncy activity, then longer holds
    for (int c = 0; c < 1600; c++) begin
      int p;
      p = (c < 800) ? 5 : 39;
      @(negedge clk);
      if ($urandom_range(0, p) == 0) west = ~west;
      if ($urandom_range(0, p) == 0) east = ~east;
      if ($urandom_range(0, 4 * p) == 0) clr = ~clr;
    end
    west = 1'b0; east = 1'b0; clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
